// File: rtl/fetch_mem_pkg.sv
// Shared types for the fetch/memory unit: bus commands, branch modes and FSM states.
package fetch_mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        BR_ABS  = 2'b00,
        BR_REL  = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter and link register with next-PC selection (increment or branch).
module pc_unit
    import fetch_mem_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 9,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc_i,
    input  logic              br_apply_i,
    input  br_mode_t          br_mode_i,
    input  logic [ADDR_W-1:0] br_operand_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] lr_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] lr_q, lr_d;

    // Additions are truncated to ADDR_W, so increment and relative branches wrap.
    always_comb begin
        pc_d = pc_q;
        lr_d = lr_q;
        if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end else if (br_apply_i) begin
            unique case (br_mode_i)
                BR_ABS:  pc_d = br_operand_i;
                BR_REL:  pc_d = pc_q + br_operand_i;
                BR_CALL: begin
                    lr_d = pc_q;
                    pc_d = br_operand_i;
                end
                BR_RET:  pc_d = lr_q;
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
            lr_q <= '0;
        end else begin
            pc_q <= pc_d;
            lr_q <= lr_d;
        end
    end

    assign pc_o = pc_q;
    assign lr_o = lr_q;

endmodule

// File: rtl/fetch_mem_unit.sv
// Fetch/load/store sequencer: owns DA, IR, memory data latch and drives the memory port.
module fetch_mem_unit
    import fetch_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              br_valid,
    input  logic [1:0]        br_mode,
    input  logic [ADDR_W-1:0] br_operand,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdata,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] lr,
    output logic              busy,
    output logic              ir_valid,
    output logic              data_done,
    output logic              br_err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] da_q, da_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic              we_q, we_d;
    logic              ir_valid_q, ir_valid_d;
    logic              data_done_q, data_done_d;
    logic              br_err_q, br_err_d;
    logic              pc_inc;
    logic              br_apply;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk          (clk),
        .reset_n      (reset_n),
        .inc_i        (pc_inc),
        .br_apply_i   (br_apply),
        .br_mode_i    (br_mode_t'(br_mode)),
        .br_operand_i (br_operand),
        .pc_o         (pc),
        .lr_o         (lr)
    );

    always_comb begin
        state_d     = state_q;
        da_d        = da_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        ir_d        = ir_q;
        mdata_d     = mdata_q;
        ir_valid_d  = 1'b0;
        data_done_d = 1'b0;
        br_err_d    = br_err_q | (br_valid && (state_q != IDLE));
        pc_inc      = 1'b0;
        br_apply    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // One action per cycle: branch beats data beats fetch.
                if (br_valid) begin
                    br_apply = 1'b1;
                end else if (data_req) begin
                    da_d    = data_addr;
                    wdata_d = wdata;
                    we_d    = data_we;
                    state_d = DATA;
                end else if (fetch_req) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    ir_d       = read_data;
                    pc_inc     = 1'b1;
                    ir_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    if (!we_q) mdata_d = read_data;
                    data_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            da_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            ir_q        <= '0;
            mdata_q     <= '0;
            ir_valid_q  <= 1'b0;
            data_done_q <= 1'b0;
            br_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            da_q        <= da_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            ir_q        <= ir_d;
            mdata_q     <= mdata_d;
            ir_valid_q  <= ir_valid_d;
            data_done_q <= data_done_d;
            br_err_q    <= br_err_d;
        end
    end

    // Bus outputs depend only on registered state, never on the request inputs.
    always_comb begin
        mem_cmd  = MEM_NONE;
        mem_addr = da_q;
        unique case (state_q)
            FETCH: begin
                mem_cmd  = MEM_READ;
                mem_addr = pc;
            end
            DATA:    mem_cmd = we_q ? MEM_WRITE : MEM_READ;
            default: mem_cmd = MEM_NONE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign write_data = wdata_q;
    assign ir         = ir_q;
    assign mdata      = mdata_q;
    assign ir_valid   = ir_valid_q;
    assign data_done  = data_done_q;
    assign br_err     = br_err_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed self-checking bench for fetch_mem_unit with hand-computed expectations.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req, data_req, data_we, br_valid, mem_ready;
    logic [8:0]  data_addr, br_operand;
    logic [15:0] wdata, read_data;
    logic [1:0]  br_mode;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr, pc, lr;
    logic [15:0] write_data, ir, mdata;
    logic        busy, ir_valid, data_done, br_err;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_mem_unit #(
        .ADDR_W   (9),
        .DATA_W   (16),
        .RESET_PC (9'h000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .wdata      (wdata),
        .br_valid   (br_valid),
        .br_mode    (br_mode),
        .br_operand (br_operand),
        .mem_ready  (mem_ready),
        .read_data  (read_data),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .ir         (ir),
        .mdata      (mdata),
        .pc         (pc),
        .lr         (lr),
        .busy       (busy),
        .ir_valid   (ir_valid),
        .data_done  (data_done),
        .br_err     (br_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [1:0] mode, input logic [8:0] op);
        br_valid   = 1'b1;
        br_mode    = mode;
        br_operand = op;
        tick();
        br_valid   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        {fetch_req, data_req, data_we, br_valid, mem_ready} = '0;
        data_addr = '0; br_operand = '0; br_mode = '0;
        wdata = '0; read_data = '0;
        #12;
        check_eq("rst_pc", pc, 0);
        check_eq("rst_lr", lr, 0);
        check_eq("rst_ir", ir, 0);
        check_eq("rst_mdata", mdata, 0);
        check_eq("rst_cmd", mem_cmd, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flags", {ir_valid, data_done, br_err}, 0);
        reset_n = 1'b1;
        tick();

        // Zero-wait fetch (mem_ready in IDLE must be ignored)
        fetch_req = 1'b1; mem_ready = 1'b1; read_data = 16'hA5A5;
        tick();
        fetch_req = 1'b0;
        check_eq("f0_cmd", mem_cmd, 1);
        check_eq("f0_addr", mem_addr, 0);
        check_eq("f0_ivalid_early", ir_valid, 0);
        tick();
        check_eq("f0_ir", ir, 16'hA5A5);
        check_eq("f0_pc", pc, 1);
        check_eq("f0_ivalid", ir_valid, 1);
        check_eq("f0_cmd_done", mem_cmd, 0);
        tick();
        check_eq("f0_ivalid_pulse", ir_valid, 0);

        // Fetch with three wait states
        mem_ready = 1'b0; read_data = 16'h5A5A; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("fw_cmd", mem_cmd, 1);
            check_eq("fw_addr", mem_addr, 1);
            check_eq("fw_busy", busy, 1);
            check_eq("fw_ir_hold", ir, 16'hA5A5);
            tick();
        end
        mem_ready = 1'b1;
        check_eq("fw_cmd_last", mem_cmd, 1);
        tick();
        check_eq("fw_ir", ir, 16'h5A5A);
        check_eq("fw_pc", pc, 2);
        check_eq("fw_ivalid", ir_valid, 1);

        // Store then load at 0x140
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h140; wdata = 16'h1234;
        tick();
        data_req = 1'b0;
        check_eq("st_cmd", mem_cmd, 2);
        check_eq("st_addr", mem_addr, 9'h140);
        check_eq("st_wdata", write_data, 16'h1234);
        tick();
        check_eq("st_done", data_done, 1);
        check_eq("st_mdata", mdata, 0);
        check_eq("st_da_keep", mem_addr, 9'h140);
        tick();
        check_eq("st_done_pulse", data_done, 0);
        data_req = 1'b1; data_we = 1'b0; read_data = 16'h1234;
        tick();
        data_req = 1'b0;
        check_eq("ld_cmd", mem_cmd, 1);
        check_eq("ld_addr", mem_addr, 9'h140);
        tick();
        check_eq("ld_mdata", mdata, 16'h1234);
        check_eq("ld_done", data_done, 1);
        tick();
        check_eq("ld_done_pulse", data_done, 0);

        // Branches
        branch(2'b00, 9'h005);
        check_eq("br_abs", pc, 5);
        branch(2'b01, 9'h1FE);
        check_eq("br_rel", pc, 3);
        branch(2'b10, 9'h080);
        check_eq("br_call_lr", lr, 3);
        check_eq("br_call_pc", pc, 9'h080);
        branch(2'b11, 9'h000);
        check_eq("br_ret_pc", pc, 3);
        check_eq("br_ret_lr", lr, 3);
        branch(2'b00, 9'h1FF);
        fetch_req = 1'b1; read_data = 16'h1111;
        tick();
        fetch_req = 1'b0;
        check_eq("wrap_addr", mem_addr, 9'h1FF);
        tick();
        check_eq("wrap_pc", pc, 0);
        check_eq("wrap_ir", ir, 16'h1111);

        // Simultaneous requests: branch wins
        fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b1; data_addr = 9'h055;
        branch(2'b00, 9'h0AA);
        fetch_req = 1'b0; data_req = 1'b0;
        check_eq("pri_pc", pc, 9'h0AA);
        check_eq("pri_busy", busy, 0);
        check_eq("pri_da", mem_addr, 9'h140);

        // Branch during FETCH: flagged and ignored
        mem_ready = 1'b0; fetch_req = 1'b1; read_data = 16'h2222;
        tick();
        fetch_req = 1'b0;
        branch(2'b00, 9'h000);
        check_eq("bbusy_err", br_err, 1);
        check_eq("bbusy_pc", pc, 9'h0AA);
        mem_ready = 1'b1;
        tick();
        check_eq("bbusy_pc_inc", pc, 9'h0AB);
        check_eq("bbusy_err_sticky", br_err, 1);

        // Reset in the middle of a waited load
        mem_ready = 1'b0; data_req = 1'b1; data_we = 1'b0; data_addr = 9'h033;
        read_data = 16'hBEEF;
        tick();
        data_req = 1'b0;
        check_eq("rd_cmd", mem_cmd, 1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("ar_cmd", mem_cmd, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_mdata", mdata, 0);
        check_eq("ar_pc", pc, 0);
        check_eq("ar_ir", ir, 0);
        check_eq("ar_err", br_err, 0);
        check_eq("ar_addr", mem_addr, 0);
        mem_ready = 1'b1;
        tick();
        check_eq("ar_done", data_done, 0);
        reset_n = 1'b1;
        tick();
        check_eq("ar_done_after", data_done, 0);
        check_eq("ar_mdata_after", mdata, 0);
        check_eq("ar_idle_cmd", mem_cmd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
- Parametrised successor to the CPU's hard-wired PC / data-address / instruction-register logic. It owns the program counter, the data address register, the instruction register and the memory data latch.
- Sequences instruction fetches and data loads/stores over a memory port with a ready handshake, so wait states are supported. It also applies branches (absolute, relative, call with link, return).
- Sits between the controller FSM (request/done pulses) and the memory bus (mem_cmd/mem_addr/mem_ready).

Parameters:
- ADDR_W, 9, width of PC, data address, link register and mem_addr.
- DATA_W, 16, instruction/data word width.
- RESET_PC, 0, PC value on reset; must be representable in ADDR_W bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  start instruction fetch at PC (pulse or level; sampled only in IDLE).
- data_req  in  1  start data access (sampled only in IDLE).
- data_we  in  1  1 = store, 0 = load; sampled with data_req.
- data_addr  in  ADDR_W  data address; latched into DA on accept.
- wdata  in  DATA_W  store data; latched on accept.
- br_valid  in  1  apply branch (sampled only in IDLE).
- br_mode  in  2  BR_ABS / BR_REL / BR_CALL / BR_RET.
- br_operand  in  ADDR_W  absolute target or two's-complement offset.
- mem_ready  in  1  memory completes the current command this cycle.
- read_data  in  DATA_W  memory read data; valid when mem_ready is high.
- mem_cmd  out  2  MEM_NONE / MEM_READ / MEM_WRITE.
- mem_addr  out  ADDR_W  PC during fetch, DA during data access, DA when idle.
- write_data  out  DATA_W  latched store data.
- ir  out  DATA_W  instruction register.
- mdata  out  DATA_W  last loaded data word.
- pc  out  ADDR_W  current PC.
- lr  out  ADDR_W  link register.
- busy  out  1  high in FETCH or DATA.
- ir_valid  out  1  one-cycle pulse when ir is updated.
- data_done  out  1  one-cycle pulse when a data access completes.
- br_err  out  1  sticky flag: br_valid seen while busy; cleared only by reset.

Behaviour:
- Reset (asynchronous, reset_n low) sets:
  - pc = RESET_PC; lr = 0; DA = 0; ir = 0; mdata = 0; write_data = 0;
  - state = IDLE; mem_cmd = MEM_NONE;
  - ir_valid = data_done = br_err = 0.
- Reset mid-transaction aborts it immediately; no partial update of ir or mdata.
- States: IDLE, FETCH, DATA.
- IDLE, priority br_valid > data_req > fetch_req; one action per cycle, others ignored that cycle:
  - br_valid, BR_ABS: pc <= br_operand.
  - br_valid, BR_REL: pc <= pc + br_operand, modulo 2^ADDR_W (wraps).
  - br_valid, BR_CALL: lr <= pc; pc <= br_operand.
  - br_valid, BR_RET: pc <= lr.
  - data_req: DA <= data_addr; write_data <= wdata; go to DATA.
  - fetch_req: go to FETCH.
- FETCH:
  - Drives mem_cmd = MEM_READ, mem_addr = pc.
  - On mem_ready: ir <= read_data; pc <= pc + 1 (wraps from 2^ADDR_W-1 to 0); ir_valid pulses next cycle; return to IDLE.
- DATA:
  - Drives mem_cmd = MEM_WRITE if the latched we is 1, else MEM_READ; mem_addr = DA.
  - On mem_ready: loads capture mdata <= read_data; data_done pulses next cycle; return to IDLE.
- Latency:
  - A zero-wait memory (mem_ready high in the first request cycle) gives request at cycle t, accept at t, memory cycle t+1, completion at t+1 edge, pulse visible at t+2.
  - Each wait cycle adds one.
- mem_cmd, mem_addr, and write_data are registered-state-derived (no combinational path from req inputs to mem_cmd).
- mem_ready while IDLE is ignored.
- fetch_req/data_req while busy are ignored; the controller must wait for the done pulse.
- br_valid while busy: ignored, and br_err <= 1.
- DA retains its value after completion; mem_addr shows DA in IDLE.
- lr is unchanged except on BR_CALL.

Decomposition:
- Package fetch_mem_pkg:
  - mem_cmd_t enum: MEM_NONE = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b10.
  - br_mode_t enum: BR_ABS = 2'b00, BR_REL = 2'b01, BR_CALL = 2'b10, BR_RET = 2'b11.
  - state_t enum: IDLE, FETCH, DATA.
- Sub-module pc_unit: pc/lr registers and next-PC computation (increment, abs, rel, call, ret, wrap). The top keeps the FSM, DA, ir, mdata and write_data.

Test Plan:
- Reset then fetch, zero-wait memory, read_data = 16'hA5A5 -> mem_cmd = READ at addr 0 for 1 cycle; ir = A5A5; pc = 1; ir_valid single pulse.
- Fetch with 3 wait cycles -> mem_cmd = READ held 4 cycles at the same addr; busy high throughout; ir unchanged until the mem_ready edge.
- Store data_addr = 9'h140, wdata = 16'h1234, then load same addr returning 16'h1234:
  - store: mem_cmd = WRITE, mem_addr = 140, write_data = 1234.
  - load: mdata = 1234; data_done pulses once per access.
- Branches:
  - pc = 5, BR_REL with operand 9'h1FE (-2) -> pc = 3.
  - pc = 9'h1FF, then fetch -> pc wraps to 0.
  - BR_CALL to 9'h080 from pc = 3 -> lr = 3, pc = 80; then BR_RET -> pc = 3.
- Simultaneous br_valid, data_req and fetch_req in IDLE -> only the branch is applied; assert br_valid during FETCH -> br_err = 1 and pc follows the normal increment.
- Assert reset_n low mid-DATA with 2 wait cycles -> outputs reset asynchronously; mdata = 0; no data_done; mem_cmd = NONE.
